// File: rtl/adder_tree_accumulator_pkg.sv
// Shared widths, adder tree depth and the {valid,last} tag carried alongside the tree.
// Pure definitions: no latency or flow control of its own.
package adder_tree_accumulator_pkg;

  localparam int DATA_W_DEF  = 16;
  localparam int ACC_W_DEF   = 24;
  localparam int CNT_W_DEF   = 8;
  localparam int TREE_STAGES = 4;

  typedef struct packed {
    logic valid;
    logic last;
  } tag_t;

  localparam int TAG_W = $bits(tag_t);

endpackage

// File: rtl/adder_tree_accumulator_if.sv
// Tree-sum input and result output bundle for the accumulator.
// The input side has no ready signal; the result side uses out_valid/out_ready.
interface adder_tree_accumulator_if #(
  parameter int DATA_W = adder_tree_accumulator_pkg::DATA_W_DEF,
  parameter int ACC_W  = adder_tree_accumulator_pkg::ACC_W_DEF,
  parameter int CNT_W  = adder_tree_accumulator_pkg::CNT_W_DEF
);

  logic              in_valid;
  logic              in_last;
  logic [DATA_W-1:0] sum_in;
  logic              out_ready;
  logic              out_valid;
  logic [ACC_W-1:0]  result;
  logic [CNT_W-1:0]  result_terms;
  logic              overflow;
  logic              overrun;

  modport master (
    output in_valid, in_last, sum_in, out_ready,
    input  out_valid, result, result_terms, overflow, overrun
  );

  modport slave (
    input  in_valid, in_last, sum_in, out_ready,
    output out_valid, result, result_terms, overflow, overrun
  );

endinterface

// File: rtl/adder_tree_accumulator_tag_delay_line.sv
// DEPTH-stage shift register with synchronous active-low clear; latency DEPTH clocks.
// Free-running, no backpressure: a new word shifts in on every non-reset edge.
module adder_tree_accumulator_tag_delay_line #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  logic [DEPTH-1:0][WIDTH-1:0] stage;

  always_ff @(posedge clk) begin
    if (!reset) begin
      stage <= '0;
    end else begin
      stage[0] <= din;
      for (int i = 1; i < DEPTH; i++) begin
        stage[i] <= stage[i-1];
      end
    end
  end

  assign dout = stage[DEPTH-1];

endmodule

// File: rtl/adder_tree_accumulator.sv
// Accumulates aligned adder tree sums into one result per group; result 1 clock after the last term's tag emerges.
// Input is never stalled; a close while the result is unaccepted overwrites it and flags overrun.
module adder_tree_accumulator
  import adder_tree_accumulator_pkg::*;
#(
  parameter int DATA_W       = DATA_W_DEF,
  parameter int ACC_W        = ACC_W_DEF,
  parameter int TREE_LATENCY = TREE_STAGES,
  parameter int CNT_W        = CNT_W_DEF,
  parameter bit SATURATE     = 1'b0
) (
  input logic                    clk,
  input logic                    reset,
  adder_tree_accumulator_if.slave bus
);

  tag_t             tag_in;
  tag_t             tag_d;
  logic [TAG_W-1:0] tag_d_raw;

  logic [ACC_W-1:0] acc;
  logic [CNT_W-1:0] cnt;
  logic             first;
  logic             grp_ovf;

  logic             out_valid_q;
  logic [ACC_W-1:0] result_q;
  logic [CNT_W-1:0] terms_q;
  logic             overflow_q;
  logic             overrun_q;

  logic [ACC_W-1:0] base;
  logic [ACC_W:0]   sum_wide;
  logic [ACC_W-1:0] acc_nxt;
  logic [CNT_W-1:0] cnt_nxt;
  logic             ovf_nxt;
  logic             close;

  assign tag_in = '{valid: bus.in_valid, last: bus.in_last};

  adder_tree_accumulator_tag_delay_line #(
    .DEPTH (TREE_LATENCY),
    .WIDTH (TAG_W)
  ) u_tag_delay (
    .clk   (clk),
    .reset (reset),
    .din   (tag_in),
    .dout  (tag_d_raw)
  );

  assign tag_d = tag_t'(tag_d_raw);

  always_comb begin
    base     = first ? '0 : acc;
    sum_wide = {1'b0, base} + {{(ACC_W + 1 - DATA_W){1'b0}}, bus.sum_in};
    ovf_nxt  = grp_ovf | sum_wide[ACC_W];
    // Once a saturating group has overflowed it must stay pinned at all-ones.
    if (SATURATE && ovf_nxt) begin
      acc_nxt = '1;
    end else begin
      acc_nxt = sum_wide[ACC_W-1:0];
    end
    cnt_nxt = cnt + CNT_W'(1);
    close   = tag_d.valid & tag_d.last;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      acc         <= '0;
      cnt         <= '0;
      first       <= 1'b1;
      grp_ovf     <= 1'b0;
      out_valid_q <= 1'b0;
      result_q    <= '0;
      terms_q     <= '0;
      overflow_q  <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      if (tag_d.valid) begin
        acc <= acc_nxt;
        if (tag_d.last) begin
          first   <= 1'b1;
          cnt     <= '0;
          grp_ovf <= 1'b0;
        end else begin
          first   <= 1'b0;
          cnt     <= cnt_nxt;
          grp_ovf <= ovf_nxt;
        end
      end

      if (close) begin
        result_q    <= acc_nxt;
        terms_q     <= cnt_nxt;
        overflow_q  <= ovf_nxt;
        out_valid_q <= 1'b1;
        if (out_valid_q && !bus.out_ready) begin
          overrun_q <= 1'b1;
        end
      end else if (out_valid_q && bus.out_ready) begin
        out_valid_q <= 1'b0;
      end
    end
  end

  assign bus.out_valid    = out_valid_q;
  assign bus.result       = result_q;
  assign bus.result_terms = terms_q;
  assign bus.overflow     = overflow_q;
  assign bus.overrun      = overrun_q;

endmodule

// File: tb/tb_adder_tree_accumulator.sv
// Drives three accumulator builds (24-bit wrap, 17-bit wrap, 17-bit saturate) from one stream,
// emulating the adder tree delay on sum_in and checking against a group-level model.
module tb_adder_tree_accumulator;
  import adder_tree_accumulator_pkg::*;

  localparam int LAT = TREE_STAGES;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid, in_last, out_ready;
  logic [15:0] sum_in;
  int          term_val;

  int checks = 0;
  int errors = 0;
  bit armed  = 1'b0;

  always #5 clk = ~clk;

  adder_tree_accumulator_if #(.DATA_W(16), .ACC_W(24), .CNT_W(8)) if0 ();
  adder_tree_accumulator_if #(.DATA_W(16), .ACC_W(17), .CNT_W(8)) if1 ();
  adder_tree_accumulator_if #(.DATA_W(16), .ACC_W(17), .CNT_W(8)) if2 ();

  assign if0.in_valid = in_valid;  assign if0.in_last = in_last;
  assign if0.sum_in   = sum_in;    assign if0.out_ready = out_ready;
  assign if1.in_valid = in_valid;  assign if1.in_last = in_last;
  assign if1.sum_in   = sum_in;    assign if1.out_ready = out_ready;
  assign if2.in_valid = in_valid;  assign if2.in_last = in_last;
  assign if2.sum_in   = sum_in;    assign if2.out_ready = out_ready;

  adder_tree_accumulator #(.DATA_W(16), .ACC_W(24), .TREE_LATENCY(LAT), .CNT_W(8), .SATURATE(1'b0))
    dut0 (.clk(clk), .reset(reset), .bus(if0.slave));
  adder_tree_accumulator #(.DATA_W(16), .ACC_W(17), .TREE_LATENCY(LAT), .CNT_W(8), .SATURATE(1'b0))
    dut1 (.clk(clk), .reset(reset), .bus(if1.slave));
  adder_tree_accumulator #(.DATA_W(16), .ACC_W(17), .TREE_LATENCY(LAT), .CNT_W(8), .SATURATE(1'b1))
    dut2 (.clk(clk), .reset(reset), .bus(if2.slave));

  logic [31:0] a_res   [3];
  logic [7:0]  a_terms [3];
  logic        a_vld   [3];
  logic        a_ovf   [3];
  logic        a_ovr   [3];

  assign a_res[0] = 32'(if0.result); assign a_terms[0] = if0.result_terms;
  assign a_vld[0] = if0.out_valid;   assign a_ovf[0] = if0.overflow; assign a_ovr[0] = if0.overrun;
  assign a_res[1] = 32'(if1.result); assign a_terms[1] = if1.result_terms;
  assign a_vld[1] = if1.out_valid;   assign a_ovf[1] = if1.overflow; assign a_ovr[1] = if1.overrun;
  assign a_res[2] = 32'(if2.result); assign a_terms[2] = if2.result_terms;
  assign a_vld[2] = if2.out_valid;   assign a_ovf[2] = if2.overflow; assign a_ovr[2] = if2.overrun;

  // Group-level reference: tags and true term values travel LAT edges, then whole-group arithmetic.
  typedef struct {
    bit     v;
    bit     l;
    longint s;
  } term_t;

  term_t  pipe[$];
  longint tot = 0;
  int     n = 0;
  int     acc_w [3] = '{24, 17, 17};
  bit     sat   [3] = '{1'b0, 1'b0, 1'b1};
  bit     e_vld [3];
  bit     e_ovf [3];
  bit     e_ovr [3];
  longint e_res [3];
  int     e_terms [3];

  task automatic model_edge();
    term_t  t;
    longint maxv;
    bit     closing;
    if (!reset) begin
      pipe.delete();
      tot = 0;
      n   = 0;
      for (int i = 0; i < 3; i++) begin
        e_vld[i] = 0; e_ovf[i] = 0; e_ovr[i] = 0; e_res[i] = 0; e_terms[i] = 0;
      end
      return;
    end
    pipe.push_back('{v: in_valid, l: in_last, s: longint'(term_val)});
    closing = 0;
    if (pipe.size() > LAT) begin
      t = pipe.pop_front();
      if (t.v) begin
        tot += t.s;
        n++;
        closing = t.l;
      end
    end
    for (int i = 0; i < 3; i++) begin
      maxv = (longint'(1) << acc_w[i]) - 1;
      if (closing) begin
        if (e_vld[i] && !out_ready) e_ovr[i] = 1;
        e_vld[i]   = 1;
        e_res[i]   = sat[i] ? ((tot > maxv) ? maxv : tot) : (tot & maxv);
        e_ovf[i]   = (tot > maxv);
        e_terms[i] = n % 256;
      end else if (e_vld[i] && out_ready) begin
        e_vld[i] = 0;
      end
    end
    if (closing) begin
      tot = 0;
      n   = 0;
    end
  endtask

  always @(posedge clk) model_edge();

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (armed) begin
      for (int i = 0; i < 3; i++) begin
        chk($sformatf("dut%0d out_valid", i), a_vld[i], e_vld[i]);
        chk($sformatf("dut%0d result", i), a_res[i], e_res[i]);
        chk($sformatf("dut%0d result_terms", i), a_terms[i], e_terms[i]);
        chk($sformatf("dut%0d overflow", i), a_ovf[i], e_ovf[i]);
        chk($sformatf("dut%0d overrun", i), a_ovr[i], e_ovr[i]);
      end
    end
  end

  // Emulated tree: sum_in shows the value applied LAT steps earlier, garbage for idle slots.
  longint tree_q[$];

  task automatic step(input bit v, input bit l, input int s, input bit rdy, input bit rn = 1'b1);
    @(posedge clk);
    #1;
    reset     = rn;
    in_valid  = v;
    in_last   = l;
    out_ready = rdy;
    term_val  = v ? s : 0;
    tree_q.push_back(v ? longint'(s) : longint'($urandom_range(0, 65535)));
    sum_in = 16'(tree_q.pop_front());
  endtask

  task automatic wait_out(input bit rdy, output int lat);
    lat = -1;
    for (int c = 1; c <= 20; c++) begin
      step(0, 0, 0, rdy);
      @(negedge clk);
      if (a_vld[0]) begin
        lat = c;
        break;
      end
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: run exceeded 1000000 time units, expected completion");
    $fatal(1);
  end

  int lat;

  initial begin
    reset = 1'b0; in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b1; sum_in = '0; term_val = 0;
    for (int i = 0; i < LAT; i++) tree_q.push_back(longint'($urandom_range(0, 65535)));
    step(0, 0, 0, 1, 0);
    step(0, 0, 0, 1, 0);
    step(0, 0, 0, 1);
    armed = 1'b1;
    @(negedge clk);
    chk("reset out_valid", a_vld[0], 0);
    chk("reset result", a_res[0], 0);
    chk("reset overrun", a_ovr[0], 0);

    // Four-term group
    step(1, 0, 100, 1); step(1, 0, 200, 1); step(1, 0, 300, 1); step(1, 1, 400, 1);
    wait_out(1, lat);
    chk("t1 latency", lat, LAT + 1);
    chk("t1 result", a_res[0], 1000);
    chk("t1 terms", a_terms[0], 4);
    chk("t1 overflow", a_ovf[0], 0);
    step(0, 0, 0, 1);
    @(negedge clk);
    chk("t1 pulse width", a_vld[0], 0);

    // Single term at the input maximum
    step(1, 1, 65535, 1);
    wait_out(1, lat);
    chk("t2 result", a_res[0], 65535);
    chk("t2 terms", a_terms[0], 1);

    // 17-bit builds: no overflow at 2 terms, overflow at 3
    step(1, 0, 65535, 1); step(1, 1, 65535, 1);
    wait_out(1, lat);
    chk("t3 wrap17 2-term", a_res[1], 131070);
    chk("t3 wrap17 2-term ovf", a_ovf[1], 0);
    chk("t3 sat17 2-term", a_res[2], 131070);
    step(1, 0, 65535, 1); step(1, 0, 65535, 1); step(1, 1, 65535, 1);
    wait_out(1, lat);
    chk("t3 wrap17 3-term", a_res[1], 65533);
    chk("t3 wrap17 3-term ovf", a_ovf[1], 1);
    chk("t3 sat17 3-term", a_res[2], 131071);
    chk("t3 sat17 3-term ovf", a_ovf[2], 1);
    chk("t3 acc24 3-term", a_res[0], 196605);

    // Gaps, plus in_last without in_valid
    step(1, 0, 10, 1); step(0, 1, 0, 1); step(0, 0, 0, 1); step(1, 1, 20, 1);
    wait_out(1, lat);
    chk("t4 gap result", a_res[0], 30);
    chk("t4 gap terms", a_terms[0], 2);

    // Overrun: two closes with no acceptance
    step(1, 1, 5, 0); step(1, 1, 7, 0);
    wait_out(0, lat);
    chk("t5 first result", a_res[0], 5);
    chk("t5 no overrun yet", a_ovr[0], 0);
    step(0, 0, 0, 0);
    @(negedge clk);
    chk("t5 overwritten result", a_res[0], 7);
    chk("t5 overwritten terms", a_terms[0], 1);
    chk("t5 overrun set", a_ovr[0], 1);
    step(0, 0, 0, 1); step(0, 0, 0, 1);
    @(negedge clk);
    chk("t5 drained", a_vld[0], 0);
    chk("t5 overrun sticky", a_ovr[0], 1);

    // Reset mid-group with a pending result
    step(1, 1, 3, 0); step(1, 0, 50, 0); step(1, 0, 60, 0);
    for (int i = 0; i < 6; i++) step(0, 0, 0, 0);
    @(negedge clk);
    chk("t6 pending before reset", a_vld[0], 1);
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 1);
    @(negedge clk);
    chk("t6 reset out_valid", a_vld[0], 0);
    chk("t6 reset result", a_res[0], 0);
    chk("t6 reset terms", a_terms[0], 0);
    chk("t6 reset overflow", a_ovf[0], 0);
    chk("t6 reset overrun", a_ovr[0], 0);
    step(1, 1, 9, 1);
    wait_out(1, lat);
    chk("t6 post-reset result", a_res[0], 9);
    chk("t6 post-reset terms", a_terms[0], 1);

    // Randomized groups, gaps and backpressure against the model
    for (int g = 0; g < 200; g++) begin
      int len;
      len = $urandom_range(1, 6);
      for (int j = 0; j < len; j++) begin
        int gaps;
        int s;
        gaps = $urandom_range(0, 2);
        for (int k = 0; k < gaps; k++) step(0, 1'($urandom_range(0, 1)), 0, ($urandom_range(0, 3) != 0));
        s = ($urandom_range(0, 3) == 0) ? 65535 : int'($urandom_range(0, 65535));
        step(1, (j == len - 1), s, ($urandom_range(0, 3) != 0));
      end
    end
    for (int i = 0; i < 12; i++) step(0, 0, 0, 1);
    @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
